// File: rtl/decoder_sweep_pkg.sv
// Shared types and helpers for the decoder_sweep block.
package decoder_pkg;

  localparam int ONEHOT_MAX = 1024;

  typedef enum logic {IDLE, SWEEP} state_e;

  // Fixed-width reference one-hot; callers slice [0:num_out-1].
  function automatic logic [0:ONEHOT_MAX-1] onehot(input int unsigned addr,
                                                   input int unsigned num_out);
    onehot = '0;
    if (addr < num_out && addr < ONEHOT_MAX) onehot[addr] = 1'b1;
  endfunction

endpackage

// File: rtl/decoder_sweep_if.sv
// Decode-request / write-enable bus between decode stage and register-file enables.
interface decoder_sweep_if #(
  parameter int ADDR_W  = 5,
  parameter int NUM_OUT = 32,
  parameter int GROUP_W = 8
);
  logic [0:ADDR_W-1]            x;
  logic                         en;
  logic                         sweep_req;
  logic [0:NUM_OUT-1]           z;
  logic [0:NUM_OUT/GROUP_W-1]   enable;
  logic                         sweep_busy;
  logic                         sweep_done;
  logic                         addr_err;

  modport master (output x, en, sweep_req,
                  input  z, enable, sweep_busy, sweep_done, addr_err);
  modport slave  (input  x, en, sweep_req,
                  output z, enable, sweep_busy, sweep_done, addr_err);
endinterface

// File: rtl/decoder_sweep_core.sv
// Combinational ADDR_W -> NUM_OUT one-hot decoder; out-of-range addresses decode to zero.
module decoder_core #(
  parameter int ADDR_W  = 5,
  parameter int NUM_OUT = 32
) (
  input  logic [ADDR_W-1:0]  addr,
  input  logic               en,
  output logic [0:NUM_OUT-1] z
);

  for (genvar k = 0; k < NUM_OUT; k++) begin : g_dec
    assign z[k] = en && (addr == ADDR_W'(k));
  end

endmodule

// File: rtl/decoder_sweep.sv
// Registered one-hot decoder with group enables and an FSM sweep for register-file init.
// Optional sticky range error: define DECODER_SWEEP_RANGE_ERR_EN.
module decoder_sweep
  import decoder_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int NUM_OUT = 32,
  parameter int GROUP_W = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  decoder_sweep_if.slave bus
);

  localparam int              NUM_GRP = NUM_OUT / GROUP_W;
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(NUM_OUT - 1);

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]    x_a, dec_addr;
  logic                 dec_en;
  logic [0:NUM_OUT-1]   z_q, z_d;
  logic [0:NUM_GRP-1]   grp_q, grp_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  assign x_a = bus.x;

  // Decoder address is the value z will show next: x in IDLE, next counter in SWEEP.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dec_addr = x_a;
    dec_en   = 1'b0;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.sweep_req) begin
          state_d  = SWEEP;
          cnt_d    = '0;
          dec_addr = '0;
          dec_en   = 1'b1;
          busy_d   = 1'b1;
        end else begin
          dec_en   = bus.en;
        end
      end
      SWEEP: begin
        if (cnt_q == LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d    = cnt_q + 1'b1;
          dec_addr = cnt_d;
          dec_en   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  decoder_core #(.ADDR_W(ADDR_W), .NUM_OUT(NUM_OUT)) u_core (
    .addr (dec_addr),
    .en   (dec_en),
    .z    (z_d)
  );

  for (genvar g = 0; g < NUM_GRP; g++) begin : g_grp
    assign grp_d[g] = |z_d[g*GROUP_W +: GROUP_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      z_q     <= '0;
      grp_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      z_q     <= z_d;
      grp_q   <= grp_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef DECODER_SWEEP_RANGE_ERR_EN
  logic err_q, err_d;
  logic x_oor;

  assign x_oor = {1'b0, x_a} >= (ADDR_W+1)'(NUM_OUT);

  always_comb begin
    err_d = err_q | ((state_q == IDLE) && bus.en && x_oor);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign bus.addr_err = err_q;
`else
  assign bus.addr_err = 1'b0;
`endif

  assign bus.z          = z_q;
  assign bus.enable     = grp_q;
  assign bus.sweep_busy = busy_q;
  assign bus.sweep_done = done_q;

endmodule

// File: tb/tb_decoder_sweep.sv
// Bench for decoder_sweep: a 32-output and a 24-output instance driven by the same stimulus.
module tb_decoder_sweep;

`ifdef DECODER_SWEEP_RANGE_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  decoder_sweep_if #(.ADDR_W(5), .NUM_OUT(32), .GROUP_W(8)) if0 ();
  decoder_sweep_if #(.ADDR_W(5), .NUM_OUT(24), .GROUP_W(8)) if1 ();

  decoder_sweep #(.ADDR_W(5), .NUM_OUT(32), .GROUP_W(8)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  decoder_sweep #(.ADDR_W(5), .NUM_OUT(24), .GROUP_W(8)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  int in_x   = 0;
  bit in_en  = 1'b0;
  bit in_req = 1'b0;

  // Model: per instance, sweeping flag, currently lit output index (-1 none), done, err.
  bit m_sw   [2];
  int m_pos  [2];
  bit m_done [2];
  bit m_err  [2];

  function automatic int n_of(int i);
    return (i == 0) ? 32 : 24;
  endfunction

  function automatic logic [63:0] ez(int idx, int n);
    return (idx < 0) ? 64'd0 : (64'd1 << (n - 1 - idx));
  endfunction

  function automatic logic [63:0] eg(int idx, int n);
    return (idx < 0) ? 64'd0 : (64'd1 << (n/8 - 1 - idx/8));
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input int x, input bit en, input bit req);
    in_x = x; in_en = en; in_req = req;
    if0.x = 5'(x); if0.en = en; if0.sweep_req = req;
    if1.x = 5'(x); if1.en = en; if1.sweep_req = req;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_sw[i] <= 1'b0; m_pos[i] <= -1; m_done[i] <= 1'b0; m_err[i] <= 1'b0;
      end else if (m_sw[i]) begin
        if (m_pos[i] < n_of(i) - 1) begin
          m_pos[i] <= m_pos[i] + 1; m_done[i] <= 1'b0;
        end else begin
          m_sw[i] <= 1'b0; m_pos[i] <= -1; m_done[i] <= 1'b1;
        end
      end else begin
        m_done[i] <= 1'b0;
        if (ERR_EN && in_en && in_x >= n_of(i)) m_err[i] <= 1'b1;
        if (in_req) begin
          m_sw[i] <= 1'b1; m_pos[i] <= 0;
        end else begin
          m_pos[i] <= (in_en && in_x < n_of(i)) ? in_x : -1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("dut0.z",      64'(if0.z),          ez(m_pos[0], 32));
      chk("dut0.enable", 64'(if0.enable),     eg(m_pos[0], 32));
      chk("dut0.busy",   64'(if0.sweep_busy), 64'(m_sw[0]));
      chk("dut0.done",   64'(if0.sweep_done), 64'(m_done[0]));
      chk("dut0.err",    64'(if0.addr_err),   64'(m_err[0]));
      chk("dut1.z",      64'(if1.z),          ez(m_pos[1], 24));
      chk("dut1.enable", 64'(if1.enable),     eg(m_pos[1], 24));
      chk("dut1.busy",   64'(if1.sweep_busy), 64'(m_sw[1]));
      chk("dut1.done",   64'(if1.sweep_done), 64'(m_done[1]));
      chk("dut1.err",    64'(if1.addr_err),   64'(m_err[1]));
    end
  end

  initial begin
    int busy_n;
    int done_n;
    set_in(0, 1'b0, 1'b0);
    #12;
    chk("rst.z",     64'(if0.z), 64'd0);
    chk("rst.en",    64'(if0.enable), 64'd0);
    chk("rst.busy",  64'(if0.sweep_busy), 64'd0);
    chk("rst.done",  64'(if0.sweep_done), 64'd0);
    chk("rst.err1",  64'(if1.addr_err), 64'd0);
    rst_n = 1'b1;
    chk_on = 1'b1;

    // Basic decode then disable
    set_in(1, 1'b1, 1'b0); tick(1);
    chk("t1.z0",   64'(if0.z), 64'h4000_0000);
    chk("t1.en0",  64'(if0.enable), 64'h8);
    chk("t1.z1",   64'(if1.z), 64'h40_0000);
    set_in(1, 1'b0, 1'b0); tick(1);
    chk("t1.zoff", 64'(if0.z), 64'd0);
    chk("t1.eoff", 64'(if0.enable), 64'd0);

    // Out of range on the 24-output instance
    set_in(30, 1'b1, 1'b0); tick(1);
    chk("t2.z1",   64'(if1.z), 64'd0);
    chk("t2.en1",  64'(if1.enable), 64'd0);
    chk("t2.err1", 64'(if1.addr_err), 64'(ERR_EN));
    chk("t2.z0",   64'(if0.z), 64'h2);
    set_in(0, 1'b1, 1'b0); tick(1);
    chk("t2.err1s", 64'(if1.addr_err), 64'(ERR_EN));
    chk("t2.z1b",   64'(if1.z), 64'h80_0000);
    chk("t2.err0",  64'(if0.addr_err), 64'd0);

    // Single-pulse sweep
    set_in(0, 1'b0, 1'b1); tick(1);
    set_in(0, 1'b0, 1'b0);
    busy_n = int'(if0.sweep_busy); done_n = int'(if0.sweep_done);
    for (int c = 0; c < 39; c++) begin
      tick(1);
      busy_n += int'(if0.sweep_busy);
      done_n += int'(if0.sweep_done);
    end
    chk("t3.busy_cycles", 64'(busy_n), 64'd32);
    chk("t3.done_pulses", 64'(done_n), 64'd1);

    // Sweep request beats a same-cycle decode
    set_in(5, 1'b1, 1'b1); tick(1);
    chk("t4.start", 64'(if0.z), 64'h8000_0000);
    set_in(5, 1'b1, 1'b0); tick(4);
    chk("t4.no5",   64'(if0.z), 64'h0800_0000);
    tick(1);
    chk("t4.at5",   64'(if0.z), 64'h0400_0000);
    set_in(0, 1'b0, 1'b0); tick(40);

    // Async reset mid-sweep
    set_in(0, 1'b0, 1'b1); tick(1);
    set_in(0, 1'b0, 1'b0); tick(10);
    chk("t5.at10", 64'(if0.z), 64'h0020_0000);
    #2 rst_n = 1'b0;
    #1;
    chk("t5.z",    64'(if0.z), 64'd0);
    chk("t5.en",   64'(if0.enable), 64'd0);
    chk("t5.busy", 64'(if0.sweep_busy), 64'd0);
    chk("t5.done", 64'(if0.sweep_done), 64'd0);
    #10 rst_n = 1'b1;
    tick(2);
    set_in(3, 1'b1, 1'b0); tick(1);
    chk("t5.dec3", 64'(if0.z), 64'h1000_0000);

    // Back-to-back sweeps with request held
    set_in(0, 1'b0, 1'b1);
    done_n = 0;
    for (int c = 0; c < 66; c++) begin
      tick(1);
      done_n += int'(if0.sweep_done);
      if (c == 33) chk("t6.restart", 64'(if0.z), 64'h8000_0000);
    end
    chk("t6.done_pulses", 64'(done_n), 64'd2);
    set_in(0, 1'b0, 1'b0); tick(40);

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decoder_sweep.md
Name: decoder_sweep

Overview:
- Parametrised, registered N-to-NUM_OUT one-hot decoder with group enables; successor to the fixed 2-to-4, 3-to-8 and 5-to-32 decoders.
- Adds an FSM-driven sweep mode that walks a one-hot strobe across every output, one per cycle. The sweep is used to clear or initialise the register file.
- Sits between the instruction decode stage and the register-file write-enable array.

Parameters:
- ADDR_W, 5, address width in bits.
- NUM_OUT, 32, number of outputs. Must satisfy NUM_OUT <= 2**ADDR_W.
- GROUP_W, 8, outputs per group enable. NUM_OUT must be a multiple of GROUP_W.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- x  in  [0:ADDR_W-1]  address. Bit 0 is the MSB.
- en  in  1  decode enable.
- sweep_req  in  1  sweep request. Sampled only in IDLE.
- z  out  [0:NUM_OUT-1]  registered one-hot output. z[k] corresponds to address k.
- enable  out  [0:NUM_OUT/GROUP_W-1]  registered group enables. enable[g] = OR of z[g*GROUP_W +: GROUP_W].
- sweep_busy  out  1  high while in SWEEP.
- sweep_done  out  1  one-cycle pulse when a sweep completes.
- addr_err  out  1  sticky out-of-range flag (see Optional Feature).

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE, sweep counter = 0.
  - z, enable, sweep_busy, sweep_done, addr_err all 0.
  - Release is synchronous to the next clk edge.
- Latency: outputs are registered; z and enable update 1 cycle after inputs are sampled. z and enable are always consistent in the same cycle.
- IDLE, sweep_req=0:
  - z <= onehot(x) when en=1 and x < NUM_OUT; otherwise z <= 0.
  - x >= NUM_OUT gives z=0 and no wrap-around.
- IDLE, sweep_req=1:
  - State <= SWEEP, counter <= 0, z <= onehot(0), sweep_busy <= 1.
  - sweep_req has priority over en; a decode requested in the same cycle is dropped.
- SWEEP:
  - x, en and sweep_req are ignored.
  - Each edge: if counter < NUM_OUT-1, then counter++ and z <= onehot(counter+1).
  - At counter == NUM_OUT-1: state <= IDLE, z <= 0, sweep_busy <= 0, sweep_done <= 1 for exactly one cycle.
  - The sweep therefore shows NUM_OUT consecutive one-hot cycles, z[0] through z[NUM_OUT-1], followed by one all-zero cycle with done.
- Back-to-back sweeps: sweep_req sampled in the IDLE cycle after done (while sweep_done=1) starts a new sweep. sweep_done deasserts on that edge.
- Reset mid-sweep: the sweep is aborted immediately, everything returns to reset values, and no sweep_done is produced.
- Invariant: z is never more than one-hot.

Optional Feature:
- Macro: DECODER_SWEEP_RANGE_ERR_EN.
- Defined:
  - addr_err is set on the edge after any IDLE cycle with en=1 and x >= NUM_OUT.
  - It stays set until rst_n.
  - Sweeps never set it.
- Undefined: addr_err is tied to 0. The port is always present so the interface stays stable.

Decomposition:
- Package decoder_pkg:
  - State typedef enum {IDLE, SWEEP}.
  - Function onehot(addr, NUM_OUT) returning the big-endian [0:NUM_OUT-1] vector.
- One sub-module, decoder_core: purely combinational ADDR_W to NUM_OUT decoder with enable.
  - Instantiated once.
  - Its address input is muxed between x (IDLE) and the sweep counter (SWEEP); its enable is en in IDLE and 1 in SWEEP.
  - Group ORs and registers live in the top level.

Test Plan (defaults ADDR_W=5, NUM_OUT=32, GROUP_W=8):
1. Reset, then x=5'b00001, en=1 → next cycle z has only bit 1 set and enable=4'b1000. Then en=0 → z=0 and enable=0.
2. Instantiate with NUM_OUT=24 and the macro defined; drive x=5'd30, en=1 → z=0 and enable=0, and addr_err=1 from the next cycle onward, still 1 after x=0.
3. Pulse sweep_req for 1 cycle → sweep_busy high for 32 cycles with z stepping bit 0 through bit 31 and enable stepping 1000, 0100, 0010, 0001; the next cycle gives z=0, sweep_busy=0, sweep_done=1 for one cycle.
4. sweep_req=1 and en=1 with x=5 in the same cycle → the sweep starts (z bit 0 set); bit 5 is not asserted until the sweep reaches counter 5.
5. Assert rst_n=0 asynchronously at sweep counter 10 → all outputs 0 immediately, no sweep_done. After release, x=3, en=1 decodes normally.
6. Hold sweep_req=1 continuously → sweeps run back-to-back, each ending with a one-cycle done pulse and restarting at z bit 0 on the following edge.
